spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter SPI_BASE, default 27'h0000000, meaning the Wishbone base address of the SPI master register block.
REQ-002 SHALL have parameter POLL_LIMIT, default 16'd1024, meaning the maximum number of status polls per byte before the block aborts.
REQ-003 SHALL have port CLK_I, input, 1, the single clock.
REQ-004 SHALL have port RST_I, input, 1, reset (synchronous, active-high).
REQ-005 SHALL have port req_i, input, 1, a read request strobe, sampled only in IDLE.
REQ-006 SHALL have port addr_i, input, 24, the flash byte address, captured with req_i.
REQ-007 SHALL have port len_i, input, 8, the byte count, captured with req_i; 0 means 256.
REQ-008 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-009 SHALL have port rd_data_o, output, 8, the received flash byte.
REQ-010 SHALL have port rd_valid_o, output, 1, a one-cycle pulse per byte.
REQ-011 SHALL have port done_o, output, 1, a one-cycle pulse at the end of a transfer.
REQ-012 SHALL have port err_o, output, 1, a one-cycle pulse on abort.
REQ-013 SHALL have Wishbone master outputs CYC_O, STB_O, WE_O (1 each), ADR_O (27), DAT_O (32), SEL_O (4).
REQ-014 SHALL have Wishbone master inputs DAT_I (32), ACK_I (1), ERR_I (1).

Function
REQ-015 SPI register map SHALL be: SPI_BASE+0x0 TX (write loads a byte and starts it), +0x4 RX (read returns {24'b0, byte}), +0x8 STATUS (bit0 = busy).
REQ-016 FSM states SHALL be IDLE, CMD, ADDR, DUMMY, POLL, DATA, RDRX, DONE, ABORT.
REQ-017 IDLE->CMD when req_i=1: capture addr_i into an address shift register and len_i into a 9-bit counter (0->256); req_i in any other state is ignored.
REQ-018 Each TX byte SHALL be one WB write to +0x0 with SEL_O=4'b0001 and DAT_O={24'b0, byte}, followed by POLL.
REQ-019 CMD SHALL send 8'h03; ADDR SHALL send 3 bytes, MSB first.
REQ-020 DATA SHALL send 8'h00; after POLL, RDRX reads +0x4, presents DAT_I[7:0] on rd_data_o, pulses rd_valid_o for 1 cycle and decrements the count.
REQ-021 POLL SHALL issue WB reads of +0x8 until DAT_I[0]=0; it SHALL then go to the next phase, and SHALL go to ABORT after POLL_LIMIT polls.
REQ-022 Each WB cycle SHALL hold CYC_O=STB_O=1 with stable ADR/DAT/WE until ACK_I or ERR_I, and SHALL drop both for at least 1 cycle between accesses.
REQ-023 ERR_I during any access SHALL go to ABORT; ABORT pulses err_o, sends no further WB cycles and returns to IDLE next cycle.
REQ-024 When the count reaches 0, the block SHALL go to DONE, pulse done_o and return to IDLE; done_o and err_o SHALL never both assert for one request.
REQ-025 The count SHALL wrap safely: 256 bytes SHALL produce exactly 256 rd_valid_o pulses, and flash address wrap is the flash device's concern.
REQ-026 Chip select is owned by the SPI master; this block SHALL only sequence bytes.

Reset
REQ-027 While RST_I is high at a clock edge, the block SHALL enter IDLE and drive CYC_O, STB_O, WE_O, busy_o, rd_valid_o, done_o and err_o to 0, and ADR_O, DAT_O, SEL_O and rd_data_o to 0.
REQ-028 Reset mid-transfer SHALL drop CYC_O immediately, with no err_o or done_o pulse.

Configuration
REQ-029 With SPI_FAST_READ_EN defined, CMD SHALL send 8'h0B and DUMMY SHALL send one 8'h00 byte (not returned) between ADDR and DATA.
REQ-030 Without SPI_FAST_READ_EN, CMD SHALL send 8'h03, the DUMMY state SHALL be unreachable and its logic removed.

Structure
REQ-031 A shared package SHALL hold the state enum, the register offsets (TX/RX/STATUS) and the command opcodes (03/0B).
REQ-032 One sub-module, spi_wb_access, SHALL perform a single WB read/write with handshake and report ack, err and rdata.

Verification
REQ-033 Bench SHALL cover: req addr=0x012345, len=2 -> WB writes 03,01,23,45,00,00 and two RX reads; rd_valid_o pulses with the model bytes A5,5A; then done_o.
REQ-034 Bench SHALL cover: len=0 -> exactly 256 rd_valid_o pulses, then done_o.
REQ-035 Bench SHALL cover: STATUS busy for 5 polls -> exactly 6 STATUS reads before the next TX.
REQ-036 Bench SHALL cover: ERR_I on the 2nd address write -> err_o pulse, no done_o, IDLE, and no further CYC_O.
REQ-037 Bench SHALL cover: STATUS stuck busy with POLL_LIMIT=8 -> err_o after 8 polls.
REQ-038 Bench SHALL cover: RST_I mid-DATA, then new req addr=0x000010, len=1 -> clean 03,00,00,10,00 sequence; with SPI_FAST_READ_EN defined, 0B and one extra 00 byte.

Source files
------------

// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash reader: FSM state encoding,
// SPI master register offsets and flash read opcodes.
package spi_flash_reader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_POLL,
        S_DATA,
        S_RDRX,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [26:0] REG_TX     = 27'h0000000;
    localparam logic [26:0] REG_RX     = 27'h0000004;
    localparam logic [26:0] REG_STATUS = 27'h0000008;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

endpackage

// File: rtl/spi_wb_access.sv
// Single Wishbone master access: launches one read or write on start,
// holds the bus until ACK/ERR, then drops CYC/STB and reports the outcome
// with one-cycle ack/err pulses and the captured read data.
module spi_wb_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic [26:0] adr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [26:0] wb_adr,
    output logic [31:0] wb_dat,
    output logic [3:0]  wb_sel,
    input  logic [31:0] wb_rdat,
    input  logic        wb_ack,
    input  logic        wb_err
);

    // Bus handshake: launch on start, hold address/data stable, release on ACK/ERR
    always_ff @(posedge clk) begin
        if (rst) begin
            ack    <= 1'b0;
            err    <= 1'b0;
            rdata  <= 32'h0;
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            wb_adr <= 27'h0;
            wb_dat <= 32'h0;
            wb_sel <= 4'h0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (wb_cyc) begin
                if (wb_ack || wb_err) begin
                    wb_cyc <= 1'b0;
                    wb_stb <= 1'b0;
                    ack    <= wb_ack && !wb_err;
                    err    <= wb_err;
                    rdata  <= wb_rdat;
                end
            end else if (start) begin
                wb_cyc <= 1'b1;
                wb_stb <= 1'b1;
                wb_we  <= wr;
                wb_adr <= adr;
                wb_dat <= wr ? {24'h0, wdata} : 32'h0;
                wb_sel <= wr ? 4'b0001 : 4'b1111;
            end
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer driving a Wishbone SPI master register block.
// Sends the read command, three address bytes and one dummy TX byte per
// data byte, polling STATUS after every TX and reading RX for each byte.
// Build option: define SPI_FAST_READ_EN to use opcode 0x0B plus one dummy
// byte between the address and the data phase.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter logic [26:0] SPI_BASE   = 27'h0000000,
    parameter logic [15:0] POLL_LIMIT = 16'd1024
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    input  logic [7:0]  len_i,
    output logic        busy_o,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    output logic        done_o,
    output logic        err_o,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [26:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        ERR_I
);

`ifdef SPI_FAST_READ_EN
    localparam bit FAST_READ = 1'b1;
`else
    localparam bit FAST_READ = 1'b0;
`endif
    localparam logic [7:0] CMD_OP     = FAST_READ ? OP_FAST_READ : OP_READ;
    localparam state_t     AFTER_ADDR = FAST_READ ? S_DUMMY : S_DATA;

    state_t      state;
    state_t      next_state;
    state_t      next_phase;
    logic [23:0] addr_sh;
    logic [8:0]  count;
    logic [1:0]  addr_idx;
    logic [15:0] poll_cnt;
    logic        issued;

    logic        start;
    logic        wr;
    logic [26:0] acc_adr;
    logic [7:0]  acc_wdata;
    logic        acc_ack;
    logic        acc_err;
    logic [31:0] acc_rdata;
    logic        unused_rdata_bits;

    assign unused_rdata_bits = ^acc_rdata[31:8];

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);
    assign err_o  = (state == S_ABORT);

    spi_wb_access u_access (
        .clk     (CLK_I),
        .rst     (RST_I),
        .start   (start),
        .wr      (wr),
        .adr     (acc_adr),
        .wdata   (acc_wdata),
        .ack     (acc_ack),
        .err     (acc_err),
        .rdata   (acc_rdata),
        .wb_cyc  (CYC_O),
        .wb_stb  (STB_O),
        .wb_we   (WE_O),
        .wb_adr  (ADR_O),
        .wb_dat  (DAT_O),
        .wb_sel  (SEL_O),
        .wb_rdat (DAT_I),
        .wb_ack  (ACK_I),
        .wb_err  (ERR_I)
    );

    // State register
    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next state and access request; each access state launches exactly one WB cycle
    always_comb begin
        next_state = state;
        start      = 1'b0;
        wr         = 1'b0;
        acc_adr    = SPI_BASE + REG_TX;
        acc_wdata  = 8'h00;
        case (state)
            S_IDLE: if (req_i) next_state = S_CMD;
            S_CMD: begin
                start     = !issued;
                wr        = 1'b1;
                acc_wdata = CMD_OP;
                if (acc_err)      next_state = S_ABORT;
                else if (acc_ack) next_state = S_POLL;
            end
            S_ADDR: begin
                start     = !issued;
                wr        = 1'b1;
                acc_wdata = addr_sh[23:16];
                if (acc_err)      next_state = S_ABORT;
                else if (acc_ack) next_state = S_POLL;
            end
`ifdef SPI_FAST_READ_EN
            S_DUMMY: begin
                start = !issued;
                wr    = 1'b1;
                if (acc_err)      next_state = S_ABORT;
                else if (acc_ack) next_state = S_POLL;
            end
`endif
            S_DATA: begin
                start = !issued;
                wr    = 1'b1;
                if (acc_err)      next_state = S_ABORT;
                else if (acc_ack) next_state = S_POLL;
            end
            S_POLL: begin
                start   = !issued;
                acc_adr = SPI_BASE + REG_STATUS;
                if (acc_err) next_state = S_ABORT;
                else if (acc_ack) begin
                    if (!acc_rdata[0])
                        next_state = next_phase;
                    else if (({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_LIMIT})
                        next_state = S_ABORT;
                end
            end
            S_RDRX: begin
                start   = !issued;
                acc_adr = SPI_BASE + REG_RX;
                if (acc_err)      next_state = S_ABORT;
                else if (acc_ack) next_state = (count == 9'd1) ? S_DONE : S_DATA;
            end
            S_DONE:  next_state = S_IDLE;
            S_ABORT: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Request capture, address shifting, byte/poll counters and read data output
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            addr_sh    <= 24'h0;
            count      <= 9'h0;
            addr_idx   <= 2'd0;
            poll_cnt   <= 16'h0;
            next_phase <= S_IDLE;
            issued     <= 1'b0;
            rd_data_o  <= 8'h00;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            if (start)                  issued <= 1'b1;
            else if (acc_ack || acc_err) issued <= 1'b0;
            case (state)
                S_IDLE: if (req_i) begin
                    addr_sh  <= addr_i;
                    count    <= (len_i == 8'd0) ? 9'd256 : {1'b0, len_i};
                    addr_idx <= 2'd0;
                end
                S_CMD: if (acc_ack) begin
                    next_phase <= S_ADDR;
                    poll_cnt   <= 16'h0;
                end
                S_ADDR: if (acc_ack) begin
                    addr_sh    <= {addr_sh[15:0], 8'h00};
                    addr_idx   <= addr_idx + 2'd1;
                    next_phase <= (addr_idx == 2'd2) ? AFTER_ADDR : S_ADDR;
                    poll_cnt   <= 16'h0;
                end
`ifdef SPI_FAST_READ_EN
                S_DUMMY: if (acc_ack) begin
                    next_phase <= S_DATA;
                    poll_cnt   <= 16'h0;
                end
`endif
                S_DATA: if (acc_ack) begin
                    next_phase <= S_RDRX;
                    poll_cnt   <= 16'h0;
                end
                S_POLL: if (acc_ack && acc_rdata[0]) poll_cnt <= poll_cnt + 16'd1;
                S_RDRX: if (acc_ack) begin
                    rd_data_o  <= acc_rdata[7:0];
                    rd_valid_o <= 1'b1;
                    count      <= count - 9'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a Wishbone SPI-master slave model.
module tb_spi_flash_reader;

    localparam logic [26:0] BASE = 27'h0001000;
    localparam int WAIT_STATES = 1;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] EXP_OP = 8'h0B;
    localparam int DUMMY_BYTES = 1;
`else
    localparam logic [7:0] EXP_OP = 8'h03;
    localparam int DUMMY_BYTES = 0;
`endif

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        req_i = 1'b0;
    logic [23:0] addr_i = 24'h0;
    logic [7:0]  len_i = 8'h0;
    logic        busy_o, rd_valid_o, done_o, err_o;
    logic [7:0]  rd_data_o;
    logic        CYC_O, STB_O, WE_O;
    logic [26:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_I = 32'h0;
    logic        ACK_I = 1'b0;
    logic        ERR_I = 1'b0;

    int checks = 0;
    int errors = 0;

    // Slave configuration (written by tests only)
    int busy_polls = 0;
    bit stuck_busy = 1'b0;
    int err_tx_idx = -1;
    int rx_base = 0;
    logic [7:0] rx_pat [4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};

    // Slave observations (written by the slave only)
    logic [7:0] tx_log [$];
    int polls_before_tx [$];
    int status_since_tx = 0;
    int status_total = 0;
    int rx_reads = 0;
    int cyc_starts = 0;
    int gap_viol = 0;
    int stab_viol = 0;
    int bad_acc = 0;
    int hold = 0;
    bit resp_prev = 1'b0;
    bit resp_now = 1'b0;
    logic cyc_prev = 1'b0;
    logic [26:0] lat_adr, slave_off;
    logic [31:0] lat_dat;
    logic [3:0]  lat_sel;
    logic        lat_we;
    logic [1:0]  ridx;

    // Monitor observations
    int rd_pulses = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    logic [7:0] rd_bytes [$];

    spi_flash_reader #(.SPI_BASE(BASE), .POLL_LIMIT(16'd8)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .req_i(req_i), .addr_i(addr_i), .len_i(len_i),
        .busy_o(busy_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .done_o(done_o), .err_o(err_o),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .SEL_O(SEL_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
    );

    always #5 CLK_I = ~CLK_I;

    // SPI master register model: answers each access after WAIT_STATES cycles on the falling edge
    initial forever begin
        @(negedge CLK_I);
        if (resp_prev && CYC_O === 1'b1) gap_viol++;
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        DAT_I = 32'h0;
        resp_now = 1'b0;
        if (CYC_O === 1'b1 && cyc_prev !== 1'b1) cyc_starts++;
        cyc_prev = CYC_O;
        if (CYC_O === 1'b1 && STB_O === 1'b1 && !resp_prev) begin
            if (hold == 0) begin
                lat_adr = ADR_O; lat_dat = DAT_O; lat_we = WE_O; lat_sel = SEL_O;
            end
            if (hold < WAIT_STATES) hold++;
            else begin
                hold = 0;
                resp_now = 1'b1;
                if (ADR_O !== lat_adr || DAT_O !== lat_dat || WE_O !== lat_we || SEL_O !== lat_sel)
                    stab_viol++;
                slave_off = ADR_O - BASE;
                if (WE_O && slave_off == 27'h0) begin
                    if (SEL_O !== 4'b0001 || DAT_O[31:8] !== 24'h0) bad_acc++;
                    polls_before_tx.push_back(status_since_tx);
                    status_since_tx = 0;
                    if (tx_log.size() == err_tx_idx) ERR_I = 1'b1;
                    else ACK_I = 1'b1;
                    tx_log.push_back(DAT_O[7:0]);
                end else if (!WE_O && slave_off == 27'h4) begin
                    ridx = 2'(rx_reads - rx_base);
                    DAT_I = {24'h0, rx_pat[ridx]};
                    rx_reads++;
                    ACK_I = 1'b1;
                end else if (!WE_O && slave_off == 27'h8) begin
                    DAT_I = {31'h0, (stuck_busy || (status_since_tx < busy_polls))};
                    status_since_tx++;
                    status_total++;
                    ACK_I = 1'b1;
                end else begin
                    bad_acc++;
                    ACK_I = 1'b1;
                end
            end
        end else if (CYC_O !== 1'b1) begin
            hold = 0;
        end
        resp_prev = resp_now;
    end

    // Pulse monitor for rd_valid_o / done_o / err_o
    initial forever begin
        @(negedge CLK_I);
        if (rd_valid_o === 1'b1) begin
            rd_pulses++;
            rd_bytes.push_back(rd_data_o);
        end
        if (done_o === 1'b1) done_pulses++;
        if (err_o === 1'b1) err_pulses++;
    end

    task automatic issue_req(input logic [23:0] a, input logic [7:0] l);
        @(negedge CLK_I);
        req_i = 1'b1; addr_i = a; len_i = l;
        @(negedge CLK_I);
        req_i = 1'b0; addr_i = 24'h0; len_i = 8'h0;
    endtask

    task automatic wait_end(input int limit, output bit fin);
        fin = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(posedge CLK_I);
            #1;
            if (done_o === 1'b1 || err_o === 1'b1) begin
                fin = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge CLK_I);
    endtask

    task automatic test_reset();
        RST_I = 1'b1;
        repeat (3) @(posedge CLK_I);
        #1;
        checks++;
        if ({CYC_O, STB_O, WE_O} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_wb_ctrl got %b want 000", {CYC_O, STB_O, WE_O});
        end
        checks++;
        if (ADR_O !== 27'h0 || DAT_O !== 32'h0 || SEL_O !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_wb_bus got adr %h dat %h sel %h want 0", ADR_O, DAT_O, SEL_O);
        end
        checks++;
        if ({busy_o, rd_valid_o, done_o, err_o} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags got %b want 0000", {busy_o, rd_valid_o, done_o, err_o});
        end
        checks++;
        if (rd_data_o !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_rd_data got %h want 00", rd_data_o);
        end
        @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (3) @(negedge CLK_I);
        checks++;
        if (busy_o !== 1'b0 || CYC_O !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset got busy %b cyc %b want 0 0", busy_o, CYC_O);
        end
    endtask

    task automatic test_basic_read();
        logic [7:0] exp [$];
        logic [7:0] got;
        int tb0, rb0, d0, e0, x0;
        bit fin;
        exp = '{EXP_OP, 8'h01, 8'h23, 8'h45};
        repeat (DUMMY_BYTES) exp.push_back(8'h00);
        exp.push_back(8'h00);
        exp.push_back(8'h00);
        tb0 = tx_log.size(); rb0 = rd_pulses; d0 = done_pulses; e0 = err_pulses; x0 = rx_reads;
        rx_base = rx_reads;
        issue_req(24'h012345, 8'd2);
        // A request while busy must be ignored
        repeat (12) @(negedge CLK_I);
        req_i = 1'b1; addr_i = 24'hFFFFFF; len_i = 8'd5;
        @(negedge CLK_I);
        req_i = 1'b0; addr_i = 24'h0; len_i = 8'h0;
        wait_end(2000, fin);
        checks++;
        if (!fin) begin errors++; $display("[TB] FAIL basic_end got timeout want done"); end
        checks++;
        if (tx_log.size() - tb0 !== exp.size()) begin
            errors++; $display("[TB] FAIL basic_tx_count got %0d want %0d", tx_log.size() - tb0, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (tb0 + i < tx_log.size()) ? tx_log[tb0 + i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("[TB] FAIL basic_tx[%0d] got %h want %h", i, got, exp[i]);
            end
        end
        checks++;
        if (rx_reads - x0 !== 2) begin
            errors++; $display("[TB] FAIL basic_rx_reads got %0d want 2", rx_reads - x0);
        end
        checks++;
        if (rd_pulses - rb0 !== 2) begin
            errors++; $display("[TB] FAIL basic_rd_pulses got %0d want 2", rd_pulses - rb0);
        end else begin
            checks++;
            if (rd_bytes[rb0] !== 8'hA5 || rd_bytes[rb0 + 1] !== 8'h5A) begin
                errors++; $display("[TB] FAIL basic_rd_bytes got %h %h want a5 5a", rd_bytes[rb0], rd_bytes[rb0 + 1]);
            end
        end
        checks++;
        if (done_pulses - d0 !== 1 || err_pulses - e0 !== 0) begin
            errors++; $display("[TB] FAIL basic_done_err got done %0d err %0d want 1 0", done_pulses - d0, err_pulses - e0);
        end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got busy %b want 0", busy_o); end
    endtask

    task automatic test_poll_busy();
        int tb0, d0;
        bit fin;
        busy_polls = 5;
        tb0 = tx_log.size(); d0 = done_pulses;
        rx_base = rx_reads;
        issue_req(24'h000100, 8'd1);
        wait_end(3000, fin);
        busy_polls = 0;
        checks++;
        if (!fin || done_pulses - d0 !== 1) begin
            errors++; $display("[TB] FAIL poll_done got fin %b done %0d want 1 1", fin, done_pulses - d0);
        end
        checks++;
        if (polls_before_tx.size() < tb0 + 2) begin
            errors++; $display("[TB] FAIL poll_count got %0d tx want >= 2", polls_before_tx.size() - tb0);
        end else if (polls_before_tx[tb0 + 1] !== 6) begin
            errors++; $display("[TB] FAIL poll_count got %0d status reads want 6", polls_before_tx[tb0 + 1]);
        end
    endtask

    task automatic test_err_addr();
        int tb0, d0, e0, c0;
        bit fin;
        tb0 = tx_log.size(); d0 = done_pulses; e0 = err_pulses;
        err_tx_idx = tx_log.size() + 2;
        issue_req(24'hABCDEF, 8'd3);
        wait_end(2000, fin);
        err_tx_idx = -1;
        checks++;
        if (!fin || err_pulses - e0 !== 1 || done_pulses - d0 !== 0) begin
            errors++; $display("[TB] FAIL err_pulse got fin %b err %0d done %0d want 1 1 0", fin, err_pulses - e0, done_pulses - d0);
        end
        checks++;
        if (tx_log.size() - tb0 !== 3) begin
            errors++; $display("[TB] FAIL err_tx_count got %0d want 3", tx_log.size() - tb0);
        end
        c0 = cyc_starts;
        repeat (20) @(negedge CLK_I);
        checks++;
        if (cyc_starts !== c0 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL err_quiet got cyc %0d busy %b want 0 0", cyc_starts - c0, busy_o);
        end
    endtask

    task automatic test_poll_limit();
        int tb0, d0, e0, s0;
        bit fin;
        tb0 = tx_log.size(); d0 = done_pulses; e0 = err_pulses; s0 = status_total;
        stuck_busy = 1'b1;
        issue_req(24'h000200, 8'd1);
        wait_end(2000, fin);
        stuck_busy = 1'b0;
        checks++;
        if (!fin || err_pulses - e0 !== 1 || done_pulses - d0 !== 0) begin
            errors++; $display("[TB] FAIL limit_err got fin %b err %0d done %0d want 1 1 0", fin, err_pulses - e0, done_pulses - d0);
        end
        checks++;
        if (status_total - s0 !== 8) begin
            errors++; $display("[TB] FAIL limit_polls got %0d want 8", status_total - s0);
        end
        checks++;
        if (tx_log.size() - tb0 !== 1 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL limit_state got tx %0d busy %b want 1 0", tx_log.size() - tb0, busy_o);
        end
    endtask

    task automatic test_len_256();
        int tb0, rb0, d0, e0, x0;
        bit fin;
        tb0 = tx_log.size(); rb0 = rd_pulses; d0 = done_pulses; e0 = err_pulses; x0 = rx_reads;
        rx_base = rx_reads;
        issue_req(24'hFFFF80, 8'd0);
        wait_end(20000, fin);
        checks++;
        if (!fin || rd_pulses - rb0 !== 256) begin
            errors++; $display("[TB] FAIL len256_pulses got fin %b pulses %0d want 1 256", fin, rd_pulses - rb0);
        end
        checks++;
        if (done_pulses - d0 !== 1 || err_pulses - e0 !== 0) begin
            errors++; $display("[TB] FAIL len256_done got done %0d err %0d want 1 0", done_pulses - d0, err_pulses - e0);
        end
        checks++;
        if (rx_reads - x0 !== 256 || tx_log.size() - tb0 !== 260 + DUMMY_BYTES) begin
            errors++; $display("[TB] FAIL len256_bus got rx %0d tx %0d want 256 %0d", rx_reads - x0, tx_log.size() - tb0, 260 + DUMMY_BYTES);
        end
        checks++;
        if (rd_pulses - rb0 >= 256 && rd_bytes[rb0 + 255] !== 8'hC3) begin
            errors++; $display("[TB] FAIL len256_last got %h want c3", rd_bytes[rb0 + 255]);
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] exp [$];
        logic [7:0] got;
        int tb0, rb0, d0, e0, n;
        bit fin;
        rb0 = rd_pulses;
        rx_base = rx_reads;
        issue_req(24'h123456, 8'd4);
        fin = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK_I);
            if (rd_pulses > rb0) begin fin = 1'b1; break; end
        end
        if (fin) begin
            fin = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge CLK_I);
                if (CYC_O === 1'b1 && WE_O === 1'b1) begin fin = 1'b1; break; end
            end
        end
        checks++;
        if (!fin) begin errors++; $display("[TB] FAIL midrst_reach got timeout want data write"); end
        d0 = done_pulses; e0 = err_pulses;
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        checks++;
        if (CYC_O !== 1'b0 || STB_O !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_drop got cyc %b stb %b busy %b want 0 0 0", CYC_O, STB_O, busy_o);
        end
        @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (4) @(negedge CLK_I);
        checks++;
        if (done_pulses !== d0 || err_pulses !== e0) begin
            errors++; $display("[TB] FAIL midrst_pulses got done %0d err %0d want 0 0", done_pulses - d0, err_pulses - e0);
        end
        exp = '{EXP_OP, 8'h00, 8'h00, 8'h10};
        repeat (DUMMY_BYTES) exp.push_back(8'h00);
        exp.push_back(8'h00);
        tb0 = tx_log.size(); rb0 = rd_pulses; d0 = done_pulses;
        rx_base = rx_reads;
        issue_req(24'h000010, 8'd1);
        wait_end(2000, fin);
        n = tx_log.size() - tb0;
        checks++;
        if (!fin || n !== exp.size()) begin
            errors++; $display("[TB] FAIL midrst_tx_count got fin %b tx %0d want 1 %0d", fin, n, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (tb0 + i < tx_log.size()) ? tx_log[tb0 + i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("[TB] FAIL midrst_tx[%0d] got %h want %h", i, got, exp[i]);
            end
        end
        checks++;
        if (rd_pulses - rb0 !== 1 || done_pulses - d0 !== 1) begin
            errors++; $display("[TB] FAIL midrst_result got rd %0d done %0d want 1 1", rd_pulses - rb0, done_pulses - d0);
        end else begin
            checks++;
            if (rd_bytes[rb0] !== 8'hA5) begin
                errors++; $display("[TB] FAIL midrst_byte got %h want a5", rd_bytes[rb0]);
            end
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (gap_viol !== 0) begin errors++; $display("[TB] FAIL bus_gap got %0d want 0", gap_viol); end
        checks++;
        if (stab_viol !== 0) begin errors++; $display("[TB] FAIL bus_stable got %0d want 0", stab_viol); end
        checks++;
        if (bad_acc !== 0) begin errors++; $display("[TB] FAIL bus_format got %0d want 0", bad_acc); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_poll_busy();
        test_err_addr();
        test_poll_limit();
        test_len_256();
        test_reset_mid_data();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
